// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_pkg
// Brief    : Shared widths, word-index slice and queued-store entry type.
// Revision : 1.0
// ============================================================================
package sb_pkg;

   localparam int SB_DATA_W = 16;
   localparam int SB_ADDR_W = 16;
   localparam int IDX_LSB   = 1;
   localparam int IDX_MSB   = 8;
   localparam int IDX_W     = IDX_MSB - IDX_LSB + 1;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

   // Same word slice data_memory uses, so aliasing matches exactly.
   function automatic logic [IDX_W-1:0] word_idx(input logic [SB_ADDR_W-1:0] addr);
      return addr[IDX_MSB:IDX_LSB];
   endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Brief    : CPU load/store port and data_memory port of the store buffer.
// Revision : 1.0
// ============================================================================
interface store_buffer_if
   import sb_pkg::*;
#(
   parameter int DATA_W = SB_DATA_W,
   parameter int ADDR_W = SB_ADDR_W
);
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_we;
   logic              cpu_re;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              sb_empty;
   logic [ADDR_W-1:0] mem_access_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write_en;
   logic              mem_read;
   logic [DATA_W-1:0] mem_read_data;

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_read_data,
      input  cpu_rdata, cpu_stall, sb_empty,
      input  mem_access_addr, mem_write_data, mem_write_en, mem_read
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_read_data,
      output cpu_rdata, cpu_stall, sb_empty,
      output mem_access_addr, mem_write_data, mem_write_en, mem_read
   );
endinterface
`default_nettype wire

// File: rtl/store_buffer_fwd.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_fwd
// Brief    : Newest-matching-entry search for load forwarding.
// Revision : 1.0
// ============================================================================
module store_buffer_fwd
   import sb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t            entries_i [DEPTH],
   input  logic [DEPTH-1:0]     valid_i,
   input  logic [PTR_W-1:0]     head_i,
   input  logic [IDX_W-1:0]     idx_i,
   output logic                 hit_o,
   output logic [SB_DATA_W-1:0] data_o
);

   logic [PTR_W-1:0] slot;

   // Walk oldest to newest from head; a later match overrides, so the newest wins.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      slot   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head_i + PTR_W'(k);
         if (valid_i[slot] && (word_idx(entries_i[slot].addr) == idx_i)) begin
            hit_o  = 1'b1;
            data_o = entries_i[slot].data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-write FIFO in front of data_memory with load forwarding.
// Revision : 1.0
// ============================================================================
module store_buffer
   import sb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = SB_DATA_W,
   parameter int ADDR_W = SB_ADDR_W
) (
   input  wire logic     clk,
   input  wire logic     rst,
   store_buffer_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

   sb_entry_t          entries_q [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [ADDR_W-1:0]  cpu_addr;
   logic [DATA_W-1:0]  fwd_data;
   logic               fwd_hit;
   logic               full;
   logic               nonempty;
   logic               store_only;
   logic               idle;
   logic               load_miss;
   logic               drain;
   logic               push;
   sb_entry_t          head_entry;
   sb_entry_t          push_entry;

   assign cpu_addr   = bus.cpu_addr;
   assign full       = (count_q == C_FULL);
   assign nonempty   = (count_q != '0);
   // A simultaneous load+store is handled as the load alone.
   assign store_only = bus.cpu_we & ~bus.cpu_re;
   assign idle       = ~bus.cpu_we & ~bus.cpu_re;
   assign load_miss  = bus.cpu_re & ~fwd_hit;
   assign drain      = ~rst & nonempty & (idle | (full & store_only) | (full & load_miss));
   assign push       = ~rst & store_only;
   assign head_entry = entries_q[head_q];

   always_comb begin
      push_entry      = '0;
      push_entry.addr = cpu_addr;
      push_entry.data = bus.cpu_wdata;
   end

   store_buffer_fwd #(
      .DEPTH (DEPTH)
   ) u_fwd (
      .entries_i (entries_q),
      .valid_i   (valid_q),
      .head_i    (head_q),
      .idx_i     (word_idx(cpu_addr)),
      .hit_o     (fwd_hit),
      .data_o    (fwd_data)
   );

   always_comb begin
      bus.cpu_rdata       = '0;
      bus.cpu_stall       = 1'b0;
      bus.mem_access_addr = cpu_addr;
      bus.mem_write_data  = '0;
      bus.mem_write_en    = 1'b0;
      bus.mem_read        = 1'b0;
      if (!rst) begin
         if (drain) begin
            bus.mem_write_en    = 1'b1;
            bus.mem_access_addr = head_entry.addr;
            bus.mem_write_data  = head_entry.data;
         end
         if (bus.cpu_re) begin
            if (fwd_hit) begin
               bus.cpu_rdata = fwd_data;
            end else if (full) begin
               bus.cpu_stall = 1'b1;
            end else begin
               bus.mem_read  = 1'b1;
               bus.cpu_rdata = bus.mem_read_data;
            end
         end
      end
   end

   assign bus.sb_empty = rst | ~nonempty;

   // When full, pop and push hit the same slot; the push must win the valid bit.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(drain);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entries_q[tail_q] <= push_entry;
      end
   end

   a_no_load_and_store : assert property (@(posedge clk) disable iff (rst)
      !(bus.cpu_we && bus.cpu_re));

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Scoreboard bench for store_buffer against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_store_buffer;
   import sb_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } st_t;

   typedef struct {
      int          tag;
      logic [15:0] rdata;
      logic        stall;
      logic        empty;
      logic [15:0] maddr;
      logic [15:0] mwdata;
      logic        mwe;
      logic        mre;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   store_buffer_if #(.DATA_W(16), .ADDR_W(16)) bus ();

   store_buffer #(
      .DEPTH  (DEPTH),
      .DATA_W (16),
      .ADDR_W (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // data_memory stand-in: combinational read, write on the clock edge
   logic [15:0] mem [256] = '{default: 16'h0000};
   assign bus.mem_read_data = mem[bus.mem_access_addr[8:1]];
   always @(posedge clk) begin
      if (bus.mem_write_en) mem[bus.mem_access_addr[8:1]] <= bus.mem_write_data;
   end

   // Reference model: pending stores as a plain queue plus a memory image
   st_t         sbq[$];
   logic [15:0] ref_mem [256] = '{default: 16'h0000};
   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int          cur_tag = 0;
   bit          last_stall = 1'b0;

   task automatic step(input bit r, input bit we, input bit re,
                       input logic [15:0] a, input logic [15:0] d);
      exp_t        e;
      st_t         s;
      bit          hit;
      bit          is_full;
      bit          do_drain;
      logic [15:0] hd;
      @(posedge clk);
      #1;
      rst           = r;
      bus.cpu_we    = we;
      bus.cpu_re    = re;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      e.tag    = cur_tag;
      e.rdata  = 16'h0000;
      e.stall  = 1'b0;
      e.empty  = r || (sbq.size() == 0);
      e.maddr  = a;
      e.mwdata = 16'h0000;
      e.mwe    = 1'b0;
      e.mre    = 1'b0;
      if (r) begin
         sbq.delete();
      end else begin
         hit = 1'b0;
         hd  = 16'h0000;
         for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
            if (!hit && sbq[i].addr[8:1] == a[8:1]) begin
               hit = 1'b1;
               hd  = sbq[i].data;
            end
         end
         is_full  = (sbq.size() == DEPTH);
         do_drain = (sbq.size() > 0) &&
                    ((!we && !re) || (is_full && we && !re) || (is_full && re && !hit));
         if (do_drain) begin
            e.mwe    = 1'b1;
            e.maddr  = sbq[0].addr;
            e.mwdata = sbq[0].data;
         end
         if (re) begin
            if (hit) e.rdata = hd;
            else if (is_full) e.stall = 1'b1;
            else begin
               e.mre   = 1'b1;
               e.rdata = ref_mem[a[8:1]];
            end
         end
         if (do_drain) begin
            ref_mem[sbq[0].addr[8:1]] = sbq[0].data;
            void'(sbq.pop_front());
         end
         if (we && !re) begin
            s.addr = a;
            s.data = d;
            sbq.push_back(s);
         end
      end
      last_stall = e.stall;
      expq.push_back(e);
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      step(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // A stalled load is reissued until the model says it proceeds.
   task automatic load(input logic [15:0] a);
      int n;
      n = 0;
      step(1'b0, 1'b0, 1'b1, a, 16'h0000);
      while (last_stall && n < 4) begin
         step(1'b0, 1'b0, 1'b1, a, 16'h0000);
         n++;
      end
   endtask

   task automatic drain_all();
      while (sbq.size() > 0) idle(1);
   endtask

   task automatic cmp(input int tag, input string nm, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL t%0d %s: got %h expected %h (time %0t)", tag, nm, act, req, $time);
      end
   endtask

   exp_t me;
   initial begin
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            me = expq.pop_front();
            cmp(me.tag, "cpu_rdata",       bus.cpu_rdata,              me.rdata);
            cmp(me.tag, "cpu_stall",       16'(bus.cpu_stall),         16'(me.stall));
            cmp(me.tag, "sb_empty",        16'(bus.sb_empty),          16'(me.empty));
            cmp(me.tag, "mem_access_addr", bus.mem_access_addr,        me.maddr);
            cmp(me.tag, "mem_write_data",  bus.mem_write_data,         me.mwdata);
            cmp(me.tag, "mem_write_en",    16'(bus.mem_write_en),      16'(me.mwe));
            cmp(me.tag, "mem_read",        16'(bus.mem_read),          16'(me.mre));
         end
      end
   end

   initial begin
      int          w;
      int          op;
      logic [15:0] ra;
      rst           = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_re    = 1'b0;
      bus.cpu_addr  = 16'h0000;
      bus.cpu_wdata = 16'h0000;

      cur_tag = 1;
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle(2);

      cur_tag = 2;
      store(16'h0010, 16'hBEEF);
      idle(2);
      load(16'h0010);

      cur_tag = 3;
      store(16'h0020, 16'h1111);
      store(16'h0020, 16'h2222);
      load(16'h0020);
      idle(2);
      load(16'h0020);

      cur_tag = 4;
      store(16'h0202, 16'hAAAA);
      load(16'h0002);
      drain_all();

      cur_tag = 5;
      store(16'h0000, 16'h0001);
      store(16'h0002, 16'h0002);
      store(16'h0004, 16'h0003);
      store(16'h0006, 16'h0004);
      store(16'h0008, 16'h0005);
      load(16'h0100);
      drain_all();

      cur_tag = 6;
      store(16'h0040, 16'h1234);
      store(16'h0042, 16'h5678);
      store(16'h0044, 16'h9ABC);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle(4);
      load(16'h0040);
      load(16'h0042);
      load(16'h0044);

      cur_tag = 7;
      for (int i = 0; i < 3000; i++) begin
         ra = 16'($urandom) & 16'h021F;
         op = int'($urandom_range(0, 99));
         if (op < 2)       step(1'b1, 1'b0, 1'b0, ra, 16'h0000);
         else if (op < 42) store(ra, 16'($urandom));
         else if (op < 75) load(ra);
         else              idle(1);
      end
      drain_all();
      idle(1);

      w = 0;
      while (expq.size() > 0 && w < 10) begin
         @(negedge clk);
         #1;
         w++;
      end
      checks++;
      if (expq.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle datapath's load/store path and data_memory.
- Stores are queued in a small in-order FIFO and written to data_memory only on idle memory cycles, or when the FIFO is full.
- Loads are served combinationally in the same cycle: from the newest matching queued store (forwarding), else from data_memory's combinational read port.

Parameters:
- DEPTH, 4, number of queued stores (power of two, at least 2)
- DATA_W, 16, data width
- ADDR_W, 16, byte address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  load/store byte address
- cpu_wdata  in  DATA_W  store data
- cpu_we  in  1  store request this cycle
- cpu_re  in  1  load request this cycle
- cpu_rdata  out  DATA_W  load result, same cycle
- cpu_stall  out  1  hold PC; retry the load next cycle
- sb_empty  out  1  no pending stores (used for halt/drain)
- mem_access_addr  out  ADDR_W  to data_memory
- mem_write_data  out  DATA_W  to data_memory
- mem_write_en  out  1  to data_memory
- mem_read  out  1  to data_memory
- mem_read_data  in  DATA_W  from data_memory (combinational)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - Clears head, tail, count and all entry valid bits. Pending stores are discarded, including on reset mid-operation.
  - While rst=1: cpu_stall=0, mem_write_en=0, mem_read=0, cpu_rdata=0, sb_empty=1.
- Word index: idx = addr[8:1]. All address matching uses idx, so aliasing is identical to data_memory.
- cpu_we and cpu_re high together is illegal. It is treated as a load only, the store is dropped, and a simulation assertion fires.
- Forward hit: cpu_re=1 and a valid entry has idx equal to cpu_addr's idx. cpu_rdata is the data of the newest matching entry (closest to tail). mem_read=0.
- Load miss, not full: mem_read=1, mem_access_addr=cpu_addr, cpu_rdata=mem_read_data, zero latency, no drain.
- Drain condition: count>0 and one of:
  - (a) cpu_re=0 and cpu_we=0 (idle)
  - (b) count==DEPTH and cpu_we=1
  - (c) count==DEPTH and cpu_re=1 and miss
- Drain action: mem_write_en=1, mem_access_addr/mem_write_data = head entry. Head is popped at the posedge.
- Store accept:
  - cpu_we=1 pushes {cpu_addr, cpu_wdata} at the tail at the posedge.
  - When full, case (b) pops and pushes in the same cycle; count stays at DEPTH, no stall. Stores never stall.
- Full load miss (c): cpu_stall=1, mem_read=0, cpu_rdata=0 for one cycle while the head drains. Next cycle count=DEPTH-1 and the load proceeds.
- Full load hit: no stall, no drain.
- Stall conditions: cpu_stall is asserted only in case (c).
- Forwarding window: forwarding sees only entries present before the current edge. The entry being drained this cycle still forwards.
- Idle outputs: when not driving the port, mem_access_addr=cpu_addr and mem_write_data=0.
- Pointer/count rules: head/tail wrap modulo DEPTH. count updates by push minus pop and never exceeds DEPTH.
- sb_empty = (count==0), registered-state derived.
- Store order to memory is strictly FIFO. Same-address stores all drain in order.

Decomposition:
- Package sb_pkg:
  - DATA_W/ADDR_W defaults
  - IDX_LSB=1, IDX_MSB=8 constants
  - entry struct {addr, data}
- Sub-module store_buffer_fwd: combinational newest-match priority search. Inputs: entry array, valid bits, head/tail, lookup idx. Outputs: hit, data.
- FIFO storage and control stay in store_buffer.

Test Plan:
1. Reset, idle 2 cycles -> sb_empty=1, cpu_stall=0, mem_write_en=0, mem_read=0.
2. Store 0x0010<=0xBEEF, then one idle cycle -> in the idle cycle mem_write_en=1, addr 0x0010, data 0xBEEF; sb_empty=1 after the edge.
3. Stores 0x0020<=0x1111 then 0x0020<=0x2222, then load 0x0020 -> cpu_rdata=0x2222, mem_read=0; two idle cycles drain 0x1111 then 0x2222 in order.
4. Store 0x0202<=0xAAAA, load 0x0002 -> hit via idx 0x01, cpu_rdata=0xAAAA.
5. Stores to 0x0000/2/4/6 with data 1..4, then store 0x0008<=5:
   - mem_write_en=1 addr 0x0000 data 1 in the same cycle, count stays 4, no stall.
   - Then load 0x0100 -> cpu_stall=1 for one cycle with drain of 0x0002.
   - Next cycle cpu_stall=0, mem_read=1, cpu_rdata=0x0000.
6. Queue 3 stores, assert rst one cycle, then idle 4 cycles -> no mem_write_en pulses; loads of those addresses return 0x0000 from memory.
